// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: arbiter FSM states and the
// default-width word / write-mask types used by the LC-3b pipeline.
package mem_port_arbiter_pkg;

  // Default-width datapath types (16-bit word, one enable per byte).
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  // Arbiter ownership state: idle, instruction port served, data port served.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one downstream memory port between the
// IF-stage instruction port (read-only) and the MEM-stage data port.
// A registered FSM grants one requester at a time, captures its command and
// presents that captured command downstream until m_resp.
// Priority on contention: data port wins.
// Optional build macro ARB_STARVE_GUARD_EN: after MAX_D_STREAK consecutive
// data grants made while the instruction port was also waiting, the
// instruction port is granted once.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int ADDR_W       = 16,
  parameter  int DATA_W       = 16,
  parameter  int MAX_D_STREAK = 4,
  localparam int BE_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction port
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  // Data port
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  // Downstream memory port
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [BE_W-1:0]   m_be,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_resp,
  // Debug / stall visibility
  output logic              grant_d
);

  arb_state_t        state_q;
  logic              m_read_q;
  logic              m_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic d_req;
  logic starve_i;
  logic take_d;
  logic take_i;

  assign d_req = d_read | d_write;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q;

  // The instruction port is forced once the data port has won enough
  // contended arbitrations in a row.
  assign starve_i = i_read && (streak_q == STREAK_MAX);

  // Saturating count of contended data grants; any instruction grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (take_i) begin
        streak_q <= '0;
      end else if (take_d && i_read && (streak_q != STREAK_MAX)) begin
        streak_q <= streak_q + 1'b1;
      end
    end
  end
`else
  assign starve_i = 1'b0;

  // MAX_D_STREAK only matters when the starvation guard is built in.
  logic unused_max_d_streak;
  assign unused_max_d_streak = (MAX_D_STREAK != 0);
`endif

  // Arbitration decision, only acted on while IDLE.
  assign take_d = d_req && !starve_i;
  assign take_i = i_read && !take_d;

  // Ownership FSM with registered downstream strobes and command capture.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (take_d) begin
            // Read+write together is illegal; resolve it as a write.
            state_q   <= ARB_SERVE_D;
            m_write_q <= d_write;
            m_read_q  <= !d_write;
            addr_q    <= d_addr;
            wdata_q   <= d_wdata;
            be_q      <= d_be;
          end else if (take_i) begin
            state_q   <= ARB_SERVE_I;
            m_write_q <= 1'b0;
            m_read_q  <= 1'b1;
            addr_q    <= i_addr;
            wdata_q   <= '0;
            be_q      <= '1;
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          // Hold the captured command until memory completes it.
          if (m_resp) begin
            state_q   <= ARB_IDLE;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          m_read_q  <= 1'b0;
          m_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Downstream command comes only from the capture registers.
  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_be    = be_q;

  // Completion is routed to the current owner in the m_resp cycle itself;
  // m_resp while IDLE reaches nobody.
  assign i_resp  = (state_q == ARB_SERVE_I) && m_resp;
  assign d_resp  = (state_q == ARB_SERVE_D) && m_resp;
  assign i_rdata = i_resp ? m_rdata : '0;
  assign d_rdata = d_resp ? m_rdata : '0;

  assign grant_d = (state_q == ARB_SERVE_D);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference of the grant rules.
module tb_mem_port_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_rdata;
  logic          d_resp;
  logic          m_read;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_rdata;
  logic          m_resp;
  logic          grant_d;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_rdata(d_rdata), .d_resp(d_resp),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_rdata(m_rdata), .m_resp(m_resp),
    .grant_d(grant_d)
  );

  // Reference grant rule: data wins contention unless the guard has seen
  // MAXS contended data wins in a row.
  function automatic bit ref_pick_d(bit ip, bit dp, int streak);
    if (!dp) return 1'b0;
    if (GUARD && ip && (streak >= MAXS)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int ref_next_streak(bit picked_d, bit ip, int streak);
    if (!picked_d) return 0;
    if (ip) return (streak + 1 > MAXS) ? MAXS : streak + 1;
    return streak;
  endfunction

  task automatic idle_inputs();
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_resp = 1'b0; m_rdata = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Bounded wait for a downstream strobe, sampled on negedges.
  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_read || m_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic resp_begin(input logic [DW-1:0] rd);
    @(posedge clk);
    #1 m_resp = 1'b1; m_rdata = rd;
    @(negedge clk);
  endtask

  task automatic resp_end();
    @(posedge clk);
    #1 m_resp = 1'b0; m_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    i_read = 1'b1; i_addr = 16'h3000;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({m_read, m_write, grant_d, i_resp, d_resp} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {m_read, m_write, grant_d, i_resp, d_resp}); end
    n_cmp++; if ({m_addr, m_wdata, m_be} !== '0) begin n_bad++; $display("FAIL reset_capture: got %h want 0", {m_addr, m_wdata, m_be}); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_read !== 1'b0) begin n_bad++; $display("FAIL reset_release_idle: m_read=%b want 0", m_read); end
    @(negedge clk);
    n_cmp++; if ({m_read, grant_d} !== 2'b10) begin n_bad++; $display("FAIL reset_first_grant: m_read,grant_d=%b want 10", {m_read, grant_d}); end
    n_cmp++; if (m_addr !== 16'h3000) begin n_bad++; $display("FAIL reset_first_addr: got %h want 3000", m_addr); end
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if ({m_read, i_resp} !== 2'b10) begin n_bad++; $display("FAIL reset_hold: m_read,i_resp=%b want 10", {m_read, i_resp}); end
    end
    resp_begin(16'h1234);
    n_cmp++; if ({i_resp, d_resp} !== 2'b10) begin n_bad++; $display("FAIL reset_resp: i_resp,d_resp=%b want 10", {i_resp, d_resp}); end
    n_cmp++; if (i_rdata !== 16'h1234) begin n_bad++; $display("FAIL reset_rdata: got %h want 1234", i_rdata); end
    n_cmp++; if (d_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_d_rdata: got %h want 0000", d_rdata); end
    resp_end();
    i_read = 1'b0;
    @(negedge clk);
    n_cmp++; if ({i_resp, m_read} !== 2'b00) begin n_bad++; $display("FAIL reset_after_resp: i_resp,m_read=%b want 00", {i_resp, m_read}); end
  endtask

  task automatic test_contention();
    bit ok;
    @(posedge clk);
    #1 i_read = 1'b1; i_addr = 16'h1100;
    d_write = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF; d_be = 2'b01;
    wait_grant(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL cont_grant_timeout: no strobe want strobe"); end
    n_cmp++; if ({m_write, m_read, grant_d} !== 3'b101) begin n_bad++; $display("FAIL cont_d_first: w,r,grant_d=%b want 101", {m_write, m_read, grant_d}); end
    n_cmp++; if ({m_addr, m_wdata, m_be} !== {16'h0040, 16'hBEEF, 2'b01}) begin n_bad++; $display("FAIL cont_d_cmd: got %h/%h/%b want 0040/beef/01", m_addr, m_wdata, m_be); end
    @(posedge clk);
    #1 d_addr = 16'h0080; d_wdata = 16'h0000; d_be = 2'b10;
    @(negedge clk);
    n_cmp++; if ({m_addr, m_wdata, m_be} !== {16'h0040, 16'hBEEF, 2'b01}) begin n_bad++; $display("FAIL hold_capture: got %h/%h/%b want 0040/beef/01", m_addr, m_wdata, m_be); end
    resp_begin(16'h5555);
    n_cmp++; if ({i_resp, d_resp} !== 2'b01) begin n_bad++; $display("FAIL cont_d_resp: i_resp,d_resp=%b want 01", {i_resp, d_resp}); end
    n_cmp++; if ({d_rdata, i_rdata} !== {16'h5555, 16'h0000}) begin n_bad++; $display("FAIL cont_d_rdata: d=%h i=%h want 5555/0000", d_rdata, i_rdata); end
    resp_end();
    d_write = 1'b0;
    @(negedge clk);
    n_cmp++; if ({m_read, m_write, grant_d} !== 3'b000) begin n_bad++; $display("FAIL cont_idle_gap: r,w,grant_d=%b want 000", {m_read, m_write, grant_d}); end
    @(negedge clk);
    n_cmp++; if ({m_read, grant_d, m_addr} !== {2'b10, 16'h1100}) begin n_bad++; $display("FAIL cont_i_second: r,grant_d=%b addr=%h want 10/1100", {m_read, grant_d}, m_addr); end
    resp_begin(16'hA5A5);
    n_cmp++; if ({i_resp, i_rdata} !== {1'b1, 16'hA5A5}) begin n_bad++; $display("FAIL cont_i_resp: resp=%b rdata=%h want 1/a5a5", i_resp, i_rdata); end
    resp_end();
    i_read = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(posedge clk);
    #1 i_read = 1'b1; i_addr = 16'h2222;
    wait_grant(ok);
    n_cmp++; if (!ok || m_read !== 1'b1) begin n_bad++; $display("FAIL mid_grant: m_read=%b want 1", m_read); end
    #1 m_resp = 1'b1; m_rdata = 16'h7777;
    #1;
    n_cmp++; if ({i_resp, i_rdata} !== {1'b1, 16'h7777}) begin n_bad++; $display("FAIL mid_pre_resp: resp=%b rdata=%h want 1/7777", i_resp, i_rdata); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({m_read, m_write, i_resp, grant_d} !== 4'b0) begin n_bad++; $display("FAIL mid_async_drop: r,w,i_resp,grant_d=%b want 0000", {m_read, m_write, i_resp, grant_d}); end
    n_cmp++; if (i_rdata !== 16'h0) begin n_bad++; $display("FAIL mid_rdata_drop: got %h want 0000", i_rdata); end
    m_resp = 1'b0; m_rdata = '0; i_read = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    d_read = 1'b1; d_addr = 16'h0033;
    @(negedge clk);
    n_cmp++; if ({m_read, grant_d} !== 2'b00) begin n_bad++; $display("FAIL mid_idle_after: r,grant_d=%b want 00", {m_read, grant_d}); end
    @(negedge clk);
    n_cmp++; if ({m_read, grant_d, m_addr} !== {2'b11, 16'h0033}) begin n_bad++; $display("FAIL mid_regrant: r,grant_d=%b addr=%h want 11/0033", {m_read, grant_d}, m_addr); end
    resp_begin(16'h0);
    resp_end();
    d_read = 1'b0;
  endtask

  task automatic test_illegal_and_idle_resp();
    bit ok;
    @(posedge clk);
    #1 d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0055; d_wdata = 16'h1357; d_be = 2'b11;
    wait_grant(ok);
    n_cmp++; if (!ok || {m_write, m_read} !== 2'b10) begin n_bad++; $display("FAIL illegal_rw: w,r=%b want 10", {m_write, m_read}); end
    resp_begin(16'h0);
    resp_end();
    d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    resp_begin(16'hFFFF);
    n_cmp++; if ({i_resp, d_resp} !== 2'b00) begin n_bad++; $display("FAIL idle_resp: i_resp,d_resp=%b want 00", {i_resp, d_resp}); end
    n_cmp++; if ({i_rdata, d_rdata} !== 32'h0) begin n_bad++; $display("FAIL idle_rdata: i=%h d=%h want 0000/0000", i_rdata, d_rdata); end
    resp_end();
    @(negedge clk);
    n_cmp++; if ({m_read, m_write, grant_d} !== 3'b000) begin n_bad++; $display("FAIL idle_stays: r,w,grant_d=%b want 000", {m_read, m_write, grant_d}); end
  endtask

  task automatic test_streak();
    bit ok;
    bit exp_d;
    int streak;
    apply_reset();
    streak = 0;
    i_read = 1'b1; i_addr = 16'h1000;
    d_read = 1'b1; d_addr = 16'h2000;
    for (int g = 0; g < 10; g++) begin
      wait_grant(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL streak_timeout[%0d]: no strobe want strobe", g); end
      exp_d = ref_pick_d(1'b1, 1'b1, streak);
      n_cmp++; if ({grant_d, m_addr} !== {exp_d, (exp_d ? 16'h2000 : 16'h1000)}) begin n_bad++; $display("FAIL streak_owner[%0d]: grant_d=%b addr=%h want %b", g, grant_d, m_addr, exp_d); end
      streak = ref_next_streak(exp_d, 1'b1, streak);
      resp_begin(DW'(g));
      n_cmp++; if ({i_resp, d_resp} !== (exp_d ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL streak_resp[%0d]: i,d=%b want d=%b", g, {i_resp, d_resp}, exp_d); end
      resp_end();
    end
    i_read = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    bit ip;
    bit dp;
    bit exp_d;
    int streak;
    int lat;
    logic [DW-1:0] rd;
    logic [DW-1:0] own_rd;
    logic [DW-1:0] oth_rd;
    apply_reset();
    streak = 0; ip = 1'b0; dp = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1'b1; i_read = 1'b1; i_addr = AW'($urandom);
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1'b1;
        case ($urandom_range(0, 2))
          0:       begin d_read = 1'b1; d_write = 1'b0; end
          1:       begin d_read = 1'b0; d_write = 1'b1; end
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_addr = AW'($urandom); d_wdata = DW'($urandom); d_be = BW'($urandom_range(0, 3));
      end
      if (!ip && !dp) begin
        ip = 1'b1; i_read = 1'b1; i_addr = AW'($urandom);
      end
      wait_grant(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_timeout[%0d]: no strobe want strobe", t); end
      exp_d = ref_pick_d(ip, dp, streak);
      n_cmp++; if (grant_d !== exp_d) begin n_bad++; $display("FAIL rnd_owner[%0d]: grant_d=%b want %b", t, grant_d, exp_d); end
      if (exp_d) begin
        n_cmp++; if ({m_addr, m_wdata, m_be, m_write, m_read} !== {d_addr, d_wdata, d_be, d_write, !d_write}) begin n_bad++; $display("FAIL rnd_d_cmd[%0d]: %h/%h/%b w%b r%b want %h/%h/%b w%b", t, m_addr, m_wdata, m_be, m_write, m_read, d_addr, d_wdata, d_be, d_write); end
      end else begin
        n_cmp++; if ({m_addr, m_write, m_read} !== {i_addr, 2'b01}) begin n_bad++; $display("FAIL rnd_i_cmd[%0d]: %h w%b r%b want %h w0 r1", t, m_addr, m_write, m_read, i_addr); end
      end
      streak = ref_next_streak(exp_d, ip, streak);
      lat = $urandom_range(0, 2);
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        n_cmp++; if ({i_resp, d_resp, m_read | m_write} !== 3'b001) begin n_bad++; $display("FAIL rnd_wait[%0d]: i,d,strobe=%b want 001", t, {i_resp, d_resp, m_read | m_write}); end
      end
      rd = DW'($urandom);
      resp_begin(rd);
      own_rd = exp_d ? d_rdata : i_rdata;
      oth_rd = exp_d ? i_rdata : d_rdata;
      n_cmp++; if ({i_resp, d_resp} !== (exp_d ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL rnd_resp[%0d]: i,d=%b want d=%b", t, {i_resp, d_resp}, exp_d); end
      n_cmp++; if ({own_rd, oth_rd} !== {rd, {DW{1'b0}}}) begin n_bad++; $display("FAIL rnd_rdata[%0d]: owner=%h other=%h want %h/0000", t, own_rd, oth_rd, rd); end
      resp_end();
      if (exp_d) begin
        dp = 1'b0; d_read = 1'b0; d_write = 1'b0;
      end else begin
        ip = 1'b0; i_read = 1'b0;
      end
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_contention();
    test_reset_mid();
    test_illegal_and_idle_resp();
    test_streak();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
